// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned N    = 32;
    localparam int unsigned ITER = N;
    localparam int unsigned CntW = $clog2(ITER);

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRem    = 3'b110;
    localparam logic [2:0] OpRemu   = 3'b111;

    localparam logic [N-1:0] MinInt = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Core-side bundle between decode/register file and the multiply/divide unit.
interface muldiv_unit_if;
    import muldiv_pkg::*;

    logic         start_i;
    logic [2:0]   op_i;
    logic [N-1:0] rs1_data_i;
    logic [N-1:0] rs2_data_i;
    logic [4:0]   rd_i;
    logic         stall_o;
    logic         done_o;
    logic [N-1:0] result_o;
    logic [4:0]   rd_o;
    logic         reg_write_o;

    modport master (
        output start_i, op_i, rs1_data_i, rs2_data_i, rd_i,
        input  stall_o, done_o, result_o, rd_o, reg_write_o
    );

    modport slave (
        input  start_i, op_i, rs1_data_i, rs2_data_i, rd_i,
        output stall_o, done_o, result_o, rd_o, reg_write_o
    );

endinterface

// File: rtl/muldiv_sign_fixup.sv
// Final sign correction, word select and div-by-zero/overflow override for the FIX cycle.
module muldiv_sign_fixup
    import muldiv_pkg::*;
(
    input  logic [2:0]     i_op,
    input  logic [2*N-1:0] i_acc,
    input  logic           i_neg_q,
    input  logic           i_neg_r,
    input  logic           i_div0,
    input  logic           i_ovf,
    input  logic [N-1:0]   i_rs1,
    output logic [N-1:0]   o_result
);

    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quot;
    logic [N-1:0]   w_rem;

    // Product sign rides on i_neg_q; the accumulator holds {rem, quot} for divides.
    assign w_prod = i_neg_q ? -i_acc : i_acc;
    assign w_quot = i_neg_q ? -i_acc[N-1:0] : i_acc[N-1:0];
    assign w_rem  = i_neg_r ? -i_acc[2*N-1:N] : i_acc[2*N-1:N];

    always_comb begin
        o_result = w_prod[N-1:0];
        unique case (i_op)
            OpMul:                     o_result = w_prod[N-1:0];
            OpMulh, OpMulhsu, OpMulhu: o_result = w_prod[2*N-1:N];
            OpDiv, OpDivu:             o_result = w_quot;
            OpRem, OpRemu:             o_result = w_rem;
        endcase
        if (i_op[2]) begin
            if (i_div0) begin
                o_result = i_op[1] ? i_rs1 : '1;
            end else if (i_ovf) begin
                o_result = i_op[1] ? '0 : MinInt;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, then one fixup cycle.
module muldiv_unit
    import muldiv_pkg::*;
(
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave mdu
);

    state_e          r_state, w_state_next;
    logic [CntW-1:0] r_cnt;
    logic [2*N-1:0]  r_acc;
    logic [N-1:0]    r_divisor;
    logic [N-1:0]    r_rs1;
    logic [2:0]      r_op;
    logic [4:0]      r_rd_pend;
    logic            r_neg_q, r_neg_r, r_div0, r_ovf;
    logic [N-1:0]    r_result;
    logic [4:0]      r_rd;

    logic            w_s1_signed, w_s2_signed, w_s1, w_s2, w_ovf;
    logic [N-1:0]    w_abs1, w_abs2;
    logic [N:0]      w_addend, w_sum;
    logic [2*N-1:0]  w_mul_next, w_div_next, w_step;
    logic [N:0]      w_part;
    logic [N+1:0]    w_trial;
    logic [N-1:0]    w_fix_result;

    assign w_s1_signed = (mdu.op_i == OpMulh) || (mdu.op_i == OpMulhsu) ||
                         (mdu.op_i == OpDiv)  || (mdu.op_i == OpRem);
    assign w_s2_signed = (mdu.op_i == OpMulh) || (mdu.op_i == OpDiv) || (mdu.op_i == OpRem);
    assign w_s1   = w_s1_signed & mdu.rs1_data_i[N-1];
    assign w_s2   = w_s2_signed & mdu.rs2_data_i[N-1];
    assign w_abs1 = w_s1 ? -mdu.rs1_data_i : mdu.rs1_data_i;
    assign w_abs2 = w_s2 ? -mdu.rs2_data_i : mdu.rs2_data_i;
    assign w_ovf  = ((mdu.op_i == OpDiv) || (mdu.op_i == OpRem)) &&
                    (mdu.rs1_data_i == MinInt) && (mdu.rs2_data_i == '1);

    // Multiply: acc = {hi, multiplier}; add multiplicand into hi when the multiplier LSB is set.
    assign w_addend   = r_acc[0] ? {1'b0, r_divisor} : '0;
    assign w_sum      = {1'b0, r_acc[2*N-1:N]} + w_addend;
    assign w_mul_next = {w_sum, r_acc[N-1:1]};

    // Divide: partial remainder after the shift needs N+1 bits before the trial subtract.
    assign w_part     = r_acc[2*N-1:N-1];
    assign w_trial    = {1'b0, w_part} - {2'b00, r_divisor};
    assign w_div_next = w_trial[N+1] ? {w_part[N-1:0], r_acc[N-2:0], 1'b0}
                                     : {w_trial[N-1:0], r_acc[N-2:0], 1'b1};
    assign w_step     = r_op[2] ? w_div_next : w_mul_next;

    muldiv_sign_fixup u_fixup (
        .i_op     (r_op),
        .i_acc    (r_acc),
        .i_neg_q  (r_neg_q),
        .i_neg_r  (r_neg_r),
        .i_div0   (r_div0),
        .i_ovf    (r_ovf),
        .i_rs1    (r_rs1),
        .o_result (w_fix_result)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (mdu.start_i) w_state_next = StCalc;
            StCalc: if (r_cnt == CntW'(ITER - 1)) w_state_next = StFix;
            StFix:  w_state_next = StDone;
            StDone: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_divisor <= '0;
            r_rs1     <= '0;
            r_op      <= '0;
            r_rd_pend <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_div0    <= 1'b0;
            r_ovf     <= 1'b0;
            r_result  <= '0;
            r_rd      <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (mdu.start_i) begin
                        r_cnt     <= '0;
                        r_acc     <= {{N{1'b0}}, w_abs1};
                        r_divisor <= w_abs2;
                        r_neg_q   <= w_s1 ^ w_s2;
                        r_neg_r   <= w_s1;
                        r_div0    <= (mdu.rs2_data_i == '0);
                        r_ovf     <= w_ovf;
                        r_rs1     <= mdu.rs1_data_i;
                        r_op      <= mdu.op_i;
                        r_rd_pend <= mdu.rd_i;
                    end
                end
                StCalc: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + CntW'(1);
                end
                StFix: begin
                    r_result <= w_fix_result;
                    r_rd     <= r_rd_pend;
                end
                StDone: ;
            endcase
        end
    end

    // Stall drops in DONE so the PC advances on the same edge the register file writes.
    assign mdu.stall_o     = ((r_state == StIdle) & mdu.start_i) |
                             (r_state == StCalc) | (r_state == StFix);
    assign mdu.done_o      = (r_state == StDone);
    assign mdu.result_o    = r_result;
    assign mdu.rd_o        = r_rd;
    assign mdu.reg_write_o = mdu.done_o & (r_rd != 5'd0);

endmodule
